// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: multi-channel PWM (prescaler, edge/center counting, double-buffered boundary updates)
module pwm_multi_channel #(
  parameter int CH = 4,
  parameter int CW = 12,
  parameter int PW = 8
) (
  input  logic             iCLK,
  input  logic             inReset,
  input  logic             iEnable,
  input  logic             iUpdate,
  input  logic [PW-1:0]    iPrescale,
  input  logic [CW-1:0]    iPeriod,
  input  logic             iMode,
  input  logic [CH*CW-1:0] iDuty,
  input  logic [CH-1:0]    iPolarity,
  output logic [CH-1:0]    oPWM,
  output logic [CW-1:0]    oCount,
  output logic             oPeriodEnd,
  output logic             oPending
);
  typedef struct packed {
    logic [PW-1:0]    pre;
    logic [CW-1:0]    per;
    logic             mode;
    logic [CH*CW-1:0] duty;
    logic [CH-1:0]    pol;
  } cfg_t;
  localparam logic [CW-1:0] ONE = CW'(1);
  cfg_t stg_q, stg_d, act_q, act_d;
  logic pend_q, pend_d, dir_q, dir_d, pe_q, pe_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d, step_cnt;
  logic [CH-1:0] pwm_q, pwm_d, raw;
  logic tick, up_top, turn, bnd, apply;
  always_comb begin
    tick = pre_q == act_q.pre;
    up_top = !dir_q && cnt_q == act_q.per;
    turn = act_q.mode && up_top && act_q.per > ONE;
    step_cnt = dir_q ? (cnt_q > ONE ? cnt_q - ONE : '0) : !up_top ? cnt_q + ONE : turn ? act_q.per - ONE : '0;
    bnd = tick && step_cnt == '0;
    apply = pend_q && (!iEnable || bnd);
    raw = '0;
    for (int n = 0; n < CH; n++) raw[n] = cnt_q < act_q.duty[n*CW +: CW];
    stg_d = iUpdate ? cfg_t'{iPrescale, iPeriod, iMode, iDuty, iPolarity} : stg_q;
    act_d = apply ? stg_q : act_q;
    pend_d = iUpdate || (pend_q && !apply);
    pre_d = (!iEnable || tick) ? '0 : pre_q + 1'b1;
    cnt_d = !iEnable ? '0 : tick ? step_cnt : cnt_q;
    dir_d = iEnable && (tick ? (turn || (dir_q && cnt_q > ONE)) : dir_q);
    pe_d = iEnable && bnd;
    pwm_d = iEnable ? raw ^ act_q.pol : act_d.pol;
  end
  always_ff @(posedge iCLK) begin
    if (!inReset) begin
      stg_q  <= '0;
      act_q  <= '0;
      pend_q <= 1'b0;
      pre_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      pe_q   <= 1'b0;
      pwm_q  <= '0;
    end else begin
      stg_q  <= stg_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      pe_q   <= pe_d;
      pwm_q  <= pwm_d;
    end
  end
  assign oPWM = pwm_q;
  assign oCount = cnt_q;
  assign oPeriodEnd = pe_q;
  assign oPending = pend_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: randomized and directed bench against a tick-index reference model
module tb_pwm_multi_channel;
  localparam int CH = 4;
  localparam int CW = 12;
  localparam int PW = 8;
  logic iCLK = 1'b0;
  logic inReset, iEnable, iUpdate, iMode;
  logic [PW-1:0] iPrescale;
  logic [CW-1:0] iPeriod;
  logic [CH*CW-1:0] iDuty;
  logic [CH-1:0] iPolarity;
  logic [CH-1:0] oPWM;
  logic [CW-1:0] oCount;
  logic oPeriodEnd, oPending;
  int checks = 0;
  int failures = 0;
  int s_pre, s_per, s_mode, a_pre, a_per, a_mode;
  int s_duty[CH];
  int a_duty[CH];
  logic [CH-1:0] s_pol, a_pol, m_pwm;
  logic m_pend, m_pe;
  int pos, div;

  always #5 iCLK = ~iCLK;

  pwm_multi_channel #(.CH(CH), .CW(CW), .PW(PW)) dut (
    .iCLK(iCLK), .inReset(inReset), .iEnable(iEnable), .iUpdate(iUpdate),
    .iPrescale(iPrescale), .iPeriod(iPeriod), .iMode(iMode), .iDuty(iDuty),
    .iPolarity(iPolarity), .oPWM(oPWM), .oCount(oCount),
    .oPeriodEnd(oPeriodEnd), .oPending(oPending)
  );

  function automatic int plen();
    return a_mode != 0 ? (a_per == 0 ? 1 : 2 * a_per) : a_per + 1;
  endfunction

  function automatic int pval();
    return (a_mode != 0 && pos > a_per) ? 2 * a_per - pos : pos;
  endfunction

  function automatic void take_staging();
    a_pre = s_pre; a_per = s_per; a_mode = s_mode; a_duty = s_duty; a_pol = s_pol;
    m_pend = 1'b0;
  endfunction

  function automatic void model_step();
    if (!inReset) begin
      s_pre = 0; s_per = 0; s_mode = 0; s_pol = '0;
      a_pre = 0; a_per = 0; a_mode = 0; a_pol = '0;
      for (int n = 0; n < CH; n++) begin s_duty[n] = 0; a_duty[n] = 0; end
      m_pend = 1'b0; pos = 0; div = 0; m_pwm = '0; m_pe = 1'b0;
    end else begin
      if (!iEnable) begin
        if (m_pend) take_staging();
        pos = 0; div = 0; m_pe = 1'b0; m_pwm = a_pol;
      end else begin
        for (int n = 0; n < CH; n++) m_pwm[n] = (pval() < a_duty[n]) ^ a_pol[n];
        m_pe = 1'b0;
        if (div == a_pre) begin
          div = 0;
          if (pos == plen() - 1) begin
            pos = 0; m_pe = 1'b1;
            if (m_pend) take_staging();
          end else pos++;
        end else div++;
      end
      if (iUpdate) begin
        s_pre = int'(iPrescale); s_per = int'(iPeriod); s_mode = int'(iMode); s_pol = iPolarity;
        for (int n = 0; n < CH; n++) s_duty[n] = int'(iDuty[n*CW +: CW]);
        m_pend = 1'b1;
      end
    end
  endfunction

  task automatic cyc();
    @(posedge iCLK);
    model_step();
    @(negedge iCLK);
  endtask

  task automatic scramble();
    iPrescale = PW'($urandom);
    iPeriod = CW'($urandom);
    iMode = 1'($urandom);
    iDuty = (CH*CW)'({$urandom, $urandom});
    iPolarity = CH'($urandom);
  endtask

  task automatic stage(input int pre, input int per, input int mode, input logic [CH*CW-1:0] duty, input logic [CH-1:0] pol);
    iPrescale = PW'(pre); iPeriod = CW'(per); iMode = 1'(mode); iDuty = duty; iPolarity = pol;
    iUpdate = 1'b1;
    cyc();
    iUpdate = 1'b0;
    scramble();
  endtask

  task automatic wait_apply(input string nm);
    int i;
    for (i = 0; i < 6000 && !(oPeriodEnd === 1'b1 && oPending === 1'b0); i++) cyc();
    checks++;
    if (!(oPeriodEnd === 1'b1 && oPending === 1'b0)) begin
      failures++;
      $display("FAIL %s_timeout pe=%b pend=%b required pe=1 pend=0 within 6000 clocks", nm, oPeriodEnd, oPending);
    end
  endtask

  task automatic test_reset();
    inReset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iEnable = 1'($urandom); iUpdate = 1'($urandom); scramble();
      cyc();
    end
    checks++;
    if ({oPWM, oCount, oPeriodEnd, oPending} !== '0) begin
      failures++;
      $display("FAIL reset pwm=%b cnt=%0d pe=%b pend=%b required all 0", oPWM, oCount, oPeriodEnd, oPending);
    end
    inReset = 1'b1; iUpdate = 1'b0; iEnable = 1'b0;
    cyc();
  endtask

  task automatic test_edge();
    int hi[CH];
    int exp_hi[CH] = '{3, 0, 10, 5};
    int pe_n = 0;
    for (int n = 0; n < CH; n++) hi[n] = 0;
    iEnable = 1'b1;
    stage(0, 9, 0, {12'd5, 12'd10, 12'd0, 12'd3}, 4'b1000);
    wait_apply("edge");
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if (oPWM !== m_pwm || oCount !== CW'(pval()) || oPeriodEnd !== m_pe || oPending !== m_pend) begin
        failures++;
        $display("FAIL edge_model t=%0t pwm=%b exp=%b cnt=%0d exp=%0d pe=%b exp=%b pend=%b exp=%b", $time, oPWM, m_pwm, oCount, pval(), oPeriodEnd, m_pe, oPending, m_pend);
      end
      if (i < 10) begin
        for (int n = 0; n < CH; n++) hi[n] += int'(oPWM[n]);
        pe_n += int'(oPeriodEnd);
      end
    end
    for (int n = 0; n < CH; n++) begin
      checks++;
      if (hi[n] != exp_hi[n]) begin
        failures++;
        $display("FAIL edge_high ch%0d high=%0d required=%0d", n, hi[n], exp_hi[n]);
      end
    end
    checks++;
    if (pe_n != 1) begin
      failures++;
      $display("FAIL edge_period_end count=%0d required=1", pe_n);
    end
  endtask

  task automatic test_center();
    int cseq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    int hi[CH];
    int pe_n = 0;
    for (int n = 0; n < CH; n++) hi[n] = 0;
    stage(1, 4, 1, {4{12'd2}}, 4'b0000);
    wait_apply("center");
    checks++;
    if (oCount !== '0) begin
      failures++;
      $display("FAIL center_start cnt=%0d required=0", oCount);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc();
      checks++;
      if (oPWM !== m_pwm || oCount !== CW'(pval()) || oPeriodEnd !== m_pe || oPending !== m_pend) begin
        failures++;
        $display("FAIL center_model t=%0t pwm=%b exp=%b cnt=%0d exp=%0d pe=%b exp=%b pend=%b exp=%b", $time, oPWM, m_pwm, oCount, pval(), oPeriodEnd, m_pe, oPending, m_pend);
      end
      if (i < 16) begin
        checks++;
        if (oCount !== CW'(cseq[i/2])) begin
          failures++;
          $display("FAIL center_seq i=%0d cnt=%0d required=%0d", i, oCount, cseq[i/2]);
        end
      end
      for (int n = 0; n < CH; n++) hi[n] += int'(oPWM[n]);
      pe_n += int'(oPeriodEnd);
    end
    for (int n = 0; n < CH; n++) begin
      checks++;
      if (hi[n] != 6) begin
        failures++;
        $display("FAIL center_high ch%0d high=%0d required=6", n, hi[n]);
      end
    end
    checks++;
    if (pe_n != 1) begin
      failures++;
      $display("FAIL center_period_end count=%0d required=1", pe_n);
    end
  endtask

  task automatic test_update();
    int exp_hi[3] = '{7, 5, 1};
    stage(0, 9, 0, {4{12'd3}}, 4'b0000);
    wait_apply("update_setup");
    for (int i = 0; i < 3; i++) cyc();
    stage(0, 9, 0, {4{12'd7}}, 4'b0000);
    checks++;
    if (oPending !== 1'b1) begin
      failures++;
      $display("FAIL update_pending pend=%b required=1", oPending);
    end
    for (int r = 0; r < 3; r++) begin
      int hi = 0;
      if (r == 0) wait_apply("update_apply");
      if (r == 1) begin
        stage(0, 9, 0, {4{12'd5}}, 4'b0000);
        for (int i = 0; i < 20 && oCount !== CW'(9); i++) cyc();
        stage(0, 9, 0, {4{12'd1}}, 4'b0000);
        checks++;
        if (oPeriodEnd !== 1'b1 || oPending !== 1'b1) begin
          failures++;
          $display("FAIL update_coincide pe=%b pend=%b required pe=1 pend=1", oPeriodEnd, oPending);
        end
      end
      if (r == 2) wait_apply("update_second");
      for (int i = 0; i < 10; i++) begin
        cyc();
        checks++;
        if (oPWM !== m_pwm || oCount !== CW'(pval()) || oPeriodEnd !== m_pe || oPending !== m_pend) begin
          failures++;
          $display("FAIL update_model t=%0t pwm=%b exp=%b cnt=%0d exp=%0d pe=%b exp=%b pend=%b exp=%b", $time, oPWM, m_pwm, oCount, pval(), oPeriodEnd, m_pe, oPending, m_pend);
        end
        hi += int'(oPWM[0]);
      end
      checks++;
      if (hi != exp_hi[r]) begin
        failures++;
        $display("FAIL update_high round=%0d high=%0d required=%0d", r, hi, exp_hi[r]);
      end
    end
  endtask

  task automatic test_disable();
    stage(0, 9, 0, {4{12'd4}}, 4'b0000);
    wait_apply("disable_setup");
    for (int i = 0; i < 3; i++) cyc();
    stage(0, 9, 0, {4{12'd6}}, 4'b0110);
    cyc();
    iEnable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (oPWM !== 4'b0110 || oCount !== '0 || oPending !== 1'b0 || oPeriodEnd !== 1'b0) begin
        failures++;
        $display("FAIL disable i=%0d pwm=%b cnt=%0d pend=%b pe=%b required pwm=0110 cnt=0 pend=0 pe=0", i, oPWM, oCount, oPending, oPeriodEnd);
      end
    end
    iEnable = 1'b1;
    cyc();
    checks++;
    if (oCount !== CW'(1) || oPWM !== 4'b1001) begin
      failures++;
      $display("FAIL reenable cnt=%0d pwm=%b required cnt=1 pwm=1001", oCount, oPWM);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++;
      if (oPWM !== m_pwm || oCount !== CW'(pval()) || oPeriodEnd !== m_pe || oPending !== m_pend) begin
        failures++;
        $display("FAIL disable_model t=%0t pwm=%b exp=%b cnt=%0d exp=%0d pe=%b exp=%b pend=%b exp=%b", $time, oPWM, m_pwm, oCount, pval(), oPeriodEnd, m_pe, oPending, m_pend);
      end
    end
  endtask

  task automatic test_extremes();
    int pe_n = 0;
    int lo = 0;
    int held = 0;
    stage(0, 0, 0, {4{12'd0}}, 4'b0000);
    wait_apply("p0");
    for (int i = 0; i < 10; i++) begin cyc(); pe_n += int'(oPeriodEnd); end
    checks++;
    if (pe_n != 10) begin
      failures++;
      $display("FAIL p0_period_end count=%0d required=10", pe_n);
    end
    stage(0, 4095, 0, {4{12'hFFF}}, 4'b0000);
    wait_apply("pmax");
    pe_n = 0;
    for (int i = 0; i < 4096; i++) begin
      cyc();
      checks++;
      if (oPWM !== m_pwm || oCount !== CW'(pval()) || oPeriodEnd !== m_pe || oPending !== m_pend) begin
        failures++;
        $display("FAIL pmax_model t=%0t pwm=%b exp=%b cnt=%0d exp=%0d pe=%b exp=%b pend=%b exp=%b", $time, oPWM, m_pwm, oCount, pval(), oPeriodEnd, m_pe, oPending, m_pend);
      end
      lo += int'(!oPWM[0]);
      pe_n += int'(oPeriodEnd);
    end
    checks++;
    if (lo != 1 || pe_n != 1) begin
      failures++;
      $display("FAIL pmax_duty low=%0d pe=%0d required low=1 pe=1", lo, pe_n);
    end
    stage(255, 9, 0, {4{12'd3}}, 4'b0000);
    wait_apply("prescale");
    for (int i = 0; i < 300 && oCount === '0; i++) begin cyc(); held++; end
    checks++;
    if (held != 256 || oCount !== CW'(1)) begin
      failures++;
      $display("FAIL prescale_tick clocks=%0d cnt=%0d required clocks=256 cnt=1", held, oCount);
    end
    for (int i = 0; i < 300; i++) cyc();
    stage(0, 9, 1, {4{12'd3}}, 4'b1111);
    inReset = 1'b0;
    cyc();
    inReset = 1'b1;
    checks++;
    if ({oPWM, oCount, oPeriodEnd, oPending} !== '0) begin
      failures++;
      $display("FAIL midreset pwm=%b cnt=%0d pe=%b pend=%b required all 0", oPWM, oCount, oPeriodEnd, oPending);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      inReset = 1'($urandom % 400 != 0);
      iEnable = 1'($urandom % 40 != 0);
      iUpdate = 1'($urandom % 12 == 0);
      iPrescale = PW'($urandom % 3);
      iPeriod = CW'($urandom % 12);
      iMode = 1'($urandom);
      for (int n = 0; n < CH; n++) iDuty[n*CW +: CW] = CW'($urandom % 15);
      iPolarity = CH'($urandom);
      cyc();
      checks++;
      if (oPWM !== m_pwm || oCount !== CW'(pval()) || oPeriodEnd !== m_pe || oPending !== m_pend) begin
        failures++;
        $display("FAIL random_model t=%0t pwm=%b exp=%b cnt=%0d exp=%0d pe=%b exp=%b pend=%b exp=%b", $time, oPWM, m_pwm, oCount, pval(), oPeriodEnd, m_pe, oPending, m_pend);
      end
    end
  endtask

  initial begin
    inReset = 1'b0; iEnable = 1'b0; iUpdate = 1'b0;
    scramble();
    test_reset();
    test_edge();
    test_center();
    test_update();
    test_disable();
    test_extremes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator: the next-generation replacement for the single-channel 12-bit fixed-period PWM in the AXI PWM IP. It adds:
- a clock prescaler and a programmable period;
- edge- or center-aligned counting;
- per-channel duty and output polarity;
- double-buffered (staging → active) register updates applied only at period boundaries, so software writes never produce glitched pulses.

## Interface
Parameters:
- CH, 4, number of PWM channels (1..16)
- CW, 12, counter/period/duty width in bits (4..16)
- PW, 8, prescaler width in bits (1..16)

Ports:
- iCLK  input  1  clock; all logic rising-edge
- inReset  input  1  synchronous, active-low reset
- iEnable  input  1  run when 1; when 0, counter held idle and outputs inactive
- iUpdate  input  1  one-cycle strobe; captures iPrescale/iPeriod/iMode/iDuty/iPolarity into staging
- iPrescale  input  PW  tick divider; tick every iPrescale+1 clocks
- iPeriod  input  CW  period value P
- iMode  input  1  0 = edge-aligned, 1 = center-aligned
- iDuty  input  CH*CW  channel n duty at [n*CW +: CW]
- iPolarity  input  CH  1 = channel output active-low
- oPWM  output  CH  PWM outputs, registered
- oCount  output  CW  active counter value
- oPeriodEnd  output  1  one-cycle pulse when a new period starts (active registers reloaded)
- oPending  output  1  staged update not yet applied

## Operation
- **Reset (inReset=0):** all registers cleared.
  - Staging and active P/duty/prescale/mode/polarity = 0.
  - Counter = 0, direction = up, prescaler = 0, pending = 0.
  - oPWM = 0, oCount = 0, oPeriodEnd = 0, oPending = 0.
- **Staging:** on iUpdate=1, all inputs are latched into staging and pending is set. Inputs are don't-care at all other times.
- **Apply:** at a boundary tick with pending=1:
  - active ← staging (prescale, period, mode, duty, polarity) on the same edge that restarts the counter;
  - pending clears, unless iUpdate=1 in that same cycle. In that case the new values go to staging and pending stays 1; the previous staging content is what gets applied.
- **Prescaler:** counts 0..active prescale. tick = 1 in the cycle where prescaler == active prescale; the prescaler then wraps to 0. Prescale 0 gives a tick every clock.
- **Edge mode** (counter sequence 0,1,…,P,0,…; period P+1 ticks):
  - Boundary = tick with counter == P.
  - P = 0 gives a boundary every tick.
- **Center mode** (counter sequence 0,1,…,P,P-1,…,1,0,1,…; period 2P ticks):
  - On a tick with dir up and counter == P: dir ← down, counter ← P-1.
  - Boundary = tick with dir down and counter == 1. Then counter ← 0, dir ← up.
  - P = 0: counter stays 0, boundary every tick. P = 1: sequence 0,1,0,1.
- **Compare (per channel n):** raw_n = (counter < duty_n), unsigned CW-bit compare; oPWM[n] ← raw_n XOR polarity_n, registered.
  - Duty 0: always inactive.
  - Edge mode: active ticks = min(D, P+1). D > P means 100%.
  - Center mode: active ticks = 2D-1 for 1 ≤ D ≤ P; D > P means 100%. The pulse is centered on counter = 0.
- **Disable (iEnable=0):**
  - counter = 0, dir = up, prescaler = 0;
  - oPWM[n] = active polarity_n (inactive level);
  - oPeriodEnd = 0;
  - if pending, active ← staging immediately and pending clears.
  - On re-enable, counting starts at 0 (up) on the first enabled clock.
- Reset mid-period overrides everything on the next edge, including any pending update.

## Timing
- Boundary tick in cycle t:
  - t+1: oCount = 0, active registers hold new values, oPeriodEnd = 1, oPending reflects the cleared flag.
  - t+2: oPWM reflects the new duty/polarity at counter 0.
- oPWM lags oCount by exactly one clock. oCount is the registered counter.
- iUpdate in cycle t: oPending = 1 at t+1.
- Counter, dir and oPeriodEnd change only on ticks.

## Test plan
- **Reset/defaults:** hold inReset=0 for 3 clocks with random inputs → oPWM=0, oCount=0, oPeriodEnd=0, oPending=0.
- **Edge mode:** CW=12, prescale=0, P=9, duty ch0=3, ch1=0, ch2=10, ch3=5 with polarity=1, then iUpdate and enable. Required:
  - per 10-clock period: ch0 high 3, ch1 always 0, ch2 always 1, ch3 low 5 / high 5;
  - oPeriodEnd every 10 clocks.
- **Center mode:** prescale=1, P=4, duty=2 → period 16 clocks; oCount sequence 0,1,2,3,4,3,2,1 each held 2 clocks; output high 3 ticks (6 clocks) centered on 0.
- **Glitch-free update:** mid-period, iUpdate with duty 3→7. Required:
  - current period still uses 3 and oPending=1;
  - new duty takes effect right after oPeriodEnd, with oPending=0;
  - iUpdate coinciding with the boundary tick applies the old staging and leaves oPending=1.
- **Disable/re-enable:** drop iEnable mid-period with a pending update → same clock edge: oPWM = polarity, oCount=0, staging applied; re-enable → count restarts from 0.
- **Extremes:** P=0 (oPeriodEnd every tick); P = 2^CW-1 with duty = 2^CW-1 (high for all but 1 tick per period); prescale = 2^PW-1 (tick every 256 clocks); reset asserted mid-period → all outputs at reset values one clock later.
